mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the CPU instruction-fetch port and the load/store port, for builds without a dual-port memory.
- Sits between cpu and a single-port ram; the CPU stalls on deasserted ready.
- Data accesses have priority. A starvation guard bounds consecutive data grants while a fetch waits.

Parameters:
- XLEN, 32, data word width.
- AW, 30, word-address width (byte address minus log2(XLEN/8) LSBs).
- MAX_DATA_STREAK, 4, maximum consecutive data grants while i_req is pending; 0 = strict data priority (guard off).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request
- i_addr  in  AW  instruction word address
- i_ready  out  1  instruction request granted this cycle
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  XLEN  instruction read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  XLEN  store data
- d_ready  out  1  data request granted this cycle
- d_rvalid  out  1  d_rdata valid (loads only)
- d_rdata  out  XLEN  load data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM word address
- ram_wdata  out  XLEN  RAM write data
- ram_rdata  in  XLEN  RAM read data, valid one cycle after ram_en & !ram_we

Behaviour:
- Grant is combinational, evaluated each cycle:
  - gnt_d = d_req & (!i_req | MAX_DATA_STREAK==0 | streak < MAX_DATA_STREAK)
  - gnt_i = i_req & !gnt_d
- i_ready = gnt_i and d_ready = gnt_d. Both are never high together.
- RAM drive:
  - gnt_d: ram_en=1, ram_we=d_we, ram_addr=d_addr, ram_wdata=d_wdata.
  - gnt_i: ram_en=1, ram_we=0, ram_addr=i_addr, ram_wdata=0.
  - No grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Requesters hold req/addr/data stable until ready. The arbiter latches no request fields.
- Streak counter, width $clog2(MAX_DATA_STREAK+1):
  - +1 on gnt_d & i_req.
  - Cleared on gnt_i or !i_req.
  - Saturates at MAX_DATA_STREAK.
- Read-owner FSM, states R_NONE / R_INST / R_DATA, next state every cycle:
  - gnt_i -> R_INST.
  - gnt_d & !d_we -> R_DATA.
  - Otherwise -> R_NONE.
  - Back-to-back grants are allowed; there is no idle bubble.
- Return path:
  - i_rvalid = (owner==R_INST); d_rvalid = (owner==R_DATA).
  - i_rdata = d_rdata = ram_rdata, passed through unregistered.
- Stores complete in their grant cycle and produce no rvalid. A store followed by a load to the same address the next cycle returns the new data (RAM write-first is not required because accesses are serialized).
- Latency: read grant at cycle N -> rvalid at N+1. Throughput is one access per cycle.
- Reset (async assert): owner=R_NONE, streak=0, i_rvalid=d_rvalid=0 immediately.
  - A read granted in the cycle before reset is dropped; no rvalid appears after deassert.
  - ram_* outputs follow the grant equations; the requester drives req low during reset.
- Simultaneous i_req & d_req at streak==MAX_DATA_STREAK: the instruction wins, then streak clears.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_istall[31:0] and perf_dstall[31:0].
  - perf_istall counts cycles with i_req & !i_ready.
  - perf_dstall counts cycles with d_req & !d_ready.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; remaining behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - owner enum (R_NONE=2'd0, R_INST=2'd1, R_DATA=2'd2)
  - perf counter width localparam PERF_W=32
- Sub-module mem_arb_perf holds the two saturating counters, instantiated only under MEM_ARB_PERF_EN.
- Grant logic and the owner FSM stay in mem_arbiter.

Test Plan:
- i_req only, i_addr=0x10, RAM[0x10]=0x00000013: i_ready=1 same cycle; next cycle i_rvalid=1, i_rdata=0x00000013; d_rvalid=0.
- d_req & d_we, addr 0x20, wdata 0xDEADBEEF; next cycle load from 0x20: store gets d_ready and ram_we=1 with no d_rvalid; load returns d_rvalid=1, d_rdata=0xDEADBEEF one cycle after its grant.
- i_req and d_req (loads) both held high for 10 cycles, MAX_DATA_STREAK=4: grant pattern is D,D,D,D,I then repeats; rvalid owners match one cycle later.
- MAX_DATA_STREAK=0, both requests held for 6 cycles: d_ready every cycle and i_ready never.
- Load granted at cycle N, reset asserted low mid-cycle N+0.5, released at N+3: d_rvalid=0 throughout and after; streak=0.
- MEM_ARB_PERF_EN defined, i_req blocked for 7 cycles by data: perf_istall=7, perf_dstall=0; reset clears both.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port RAM arbiter.
// Read-owner encoding and performance counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_INST = 2'd1,
        R_DATA = 2'd2
    } owner_e;

    localparam int PERF_W = 32;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating stall counters for the arbiter's two request ports.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              d_stall,
    output logic [PERF_W-1:0] perf_istall,
    output logic [PERF_W-1:0] perf_dstall
);

    localparam logic [PERF_W-1:0] ONE = PERF_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_istall <= '0;
            perf_dstall <= '0;
        end else begin
            if (i_stall && perf_istall != '1) begin
                perf_istall <= perf_istall + ONE;
            end
            if (d_stall && perf_dstall != '1) begin
                perf_dstall <= perf_dstall + ONE;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Data-priority arbiter sharing one single-port RAM between fetch and load/store.
// Define MEM_ARB_PERF_EN to add the perf_istall/perf_dstall counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int AW              = 30,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ready,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ready,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            ram_en,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [XLEN-1:0] ram_wdata,
    input  logic [XLEN-1:0] ram_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_istall,
    output logic [PERF_W-1:0] perf_dstall
`endif
);

    // A zero-width counter is illegal, so the guard-off build keeps one bit.
    localparam int SW = (MAX_DATA_STREAK > 0) ?
                        $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);
    localparam logic [SW-1:0] SONE = SW'(1);

    logic [SW-1:0] streak;
    logic          guard_ok;
    logic          gnt_d;
    logic          gnt_i;
    owner_e        owner_q;
    owner_e        owner_d;

    assign guard_ok = (MAX_DATA_STREAK == 0) || (streak < SMAX);
    assign gnt_d    = d_req & (~i_req | guard_ok);
    assign gnt_i    = i_req & ~gnt_d;

    assign i_ready  = gnt_i;
    assign d_ready  = gnt_d;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (1'b1)
            gnt_d: begin
                ram_en    = 1'b1;
                ram_we    = d_we;
                ram_addr  = d_addr;
                ram_wdata = d_wdata;
            end
            gnt_i: begin
                ram_en    = 1'b1;
                ram_addr  = i_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (gnt_i || !i_req) begin
            streak <= '0;
        end else if (gnt_d && streak != SMAX) begin
            streak <= streak + SONE;
        end
    end

    // The owner tags who issued last cycle's read, steering the RAM output.
    always_comb begin
        owner_d = R_NONE;
        unique case (1'b1)
            gnt_i:          owner_d = R_INST;
            (gnt_d & ~d_we): owner_d = R_DATA;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q <= R_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign i_rvalid = (owner_q == R_INST);
    assign d_rvalid = (owner_q == R_DATA);
    assign i_rdata  = ram_rdata;
    assign d_rdata  = ram_rdata;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clock       (clock),
        .reset       (reset),
        .i_stall     (i_req & ~gnt_i),
        .d_stall     (d_req & ~gnt_d),
        .perf_istall (perf_istall),
        .perf_dstall (perf_dstall)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
// A second instance runs with the starvation guard off (MAX_DATA_STREAK=0).
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 30;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            i_req, d_req, d_we;
    logic [AW-1:0]   i_addr, d_addr;
    logic [XLEN-1:0] d_wdata;

    logic            i_ready, i_rvalid, d_ready, d_rvalid;
    logic [XLEN-1:0] i_rdata, d_rdata;
    logic            ram_en, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [XLEN-1:0] ram_wdata, ram_rdata;

    logic            z_i_ready, z_i_rvalid, z_d_ready, z_d_rvalid;
    logic [XLEN-1:0] z_i_rdata, z_d_rdata;
    logic            z_ram_en, z_ram_we;
    logic [AW-1:0]   z_ram_addr;
    logic [XLEN-1:0] z_ram_wdata;
    logic [XLEN-1:0] z_ram_rdata = '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_istall, perf_dstall;
    logic [31:0] z_perf_istall, z_perf_dstall;
`endif

    logic [XLEN-1:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[7:0]];
    end

    mem_arbiter #(.XLEN(XLEN), .AW(AW), .MAX_DATA_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
`ifdef MEM_ARB_PERF_EN
        .perf_istall(perf_istall), .perf_dstall(perf_dstall),
`endif
        .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.XLEN(XLEN), .AW(AW), .MAX_DATA_STREAK(0)) dut0 (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(z_i_ready),
        .i_rvalid(z_i_rvalid), .i_rdata(z_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(z_d_ready), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
        .ram_en(z_ram_en), .ram_we(z_ram_we), .ram_addr(z_ram_addr),
        .ram_wdata(z_ram_wdata),
`ifdef MEM_ARB_PERF_EN
        .perf_istall(z_perf_istall), .perf_dstall(z_perf_dstall),
`endif
        .ram_rdata(z_ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic expd;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

        step(); step();
        chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_streak", 32'(dut.streak), 32'd0);
        reset = 1;
        step();

        // store 0x13 to 0x10 (the instruction word fetched later)
        d_req = 1; d_we = 1; d_addr = 30'h10; d_wdata = 32'h0000_0013;
        #1;
        chk("st0_d_ready", 32'(d_ready), 32'd1);
        chk("st0_ram_we", 32'(ram_we), 32'd1);
        chk("st0_ram_addr", 32'(ram_addr), 32'h10);
        chk("st0_ram_wdata", ram_wdata, 32'h13);
        step();
        chk("st0_no_rvalid", 32'(d_rvalid), 32'd0);

        d_addr = 30'h20; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("st1_d_ready", 32'(d_ready), 32'd1);
        chk("st1_i_ready", 32'(i_ready), 32'd0);
        step();
        chk("st1_no_rvalid", 32'(d_rvalid), 32'd0);

        d_we = 0;
        #1;
        chk("ld_d_ready", 32'(d_ready), 32'd1);
        chk("ld_ram_we", 32'(ram_we), 32'd0);
        step();
        chk("ld_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("ld_i_rvalid", 32'(i_rvalid), 32'd0);

        d_req = 0; i_req = 1; i_addr = 30'h10;
        #1;
        chk("if_i_ready", 32'(i_ready), 32'd1);
        chk("if_d_ready", 32'(d_ready), 32'd0);
        chk("if_ram_addr", 32'(ram_addr), 32'h10);
        chk("if_ram_wdata", ram_wdata, 32'd0);
        step();
        chk("if_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("if_i_rdata", i_rdata, 32'h13);
        chk("if_d_rvalid", 32'(d_rvalid), 32'd0);

        i_req = 0;
        #1;
        chk("idle_ram_en", 32'(ram_en), 32'd0);
        chk("idle_ram_addr", 32'(ram_addr), 32'd0);
        step();
        chk("idle_i_rvalid", 32'(i_rvalid), 32'd0);

        // both requesting loads: D,D,D,D,I repeating; guard-off copy always D
        i_req = 1; i_addr = 30'h10;
        d_req = 1; d_we = 0; d_addr = 30'h20;
        for (int k = 0; k < 10; k++) begin
            expd = (k % 5) != 4;
            #1;
            chk($sformatf("arb%0d_d_ready", k), 32'(d_ready), 32'(expd));
            chk($sformatf("arb%0d_i_ready", k), 32'(i_ready), 32'(!expd));
            chk($sformatf("g0_%0d_d_ready", k), 32'(z_d_ready), 32'd1);
            chk($sformatf("g0_%0d_i_ready", k), 32'(z_i_ready), 32'd0);
            step();
            chk($sformatf("arb%0d_d_rvalid", k), 32'(d_rvalid), 32'(expd));
            chk($sformatf("arb%0d_i_rvalid", k), 32'(i_rvalid), 32'(!expd));
            chk($sformatf("arb%0d_rdata", k), d_rdata,
                expd ? 32'hDEAD_BEEF : 32'h13);
        end
        i_req = 0; d_req = 0;
        step();

        // load granted, then reset asserted mid-cycle before it completes
        i_req = 1; d_req = 1;
        step(); step();
        chk("pre_rst_streak", 32'(dut.streak), 32'd2);
        #1;
        chk("pre_rst_d_ready", 32'(d_ready), 32'd1);
        @(negedge clock);
        reset = 0; i_req = 0; d_req = 0;
        #1;
        chk("arst_streak", 32'(dut.streak), 32'd0);
        chk("arst_d_rvalid", 32'(d_rvalid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("inrst%0d_d_rvalid", k), 32'(d_rvalid), 32'd0);
        end
        reset = 1;
        step();
        chk("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("post_rst_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("post_rst_streak", 32'(dut.streak), 32'd0);

`ifdef MEM_ARB_PERF_EN
        i_req = 1; d_req = 1; d_we = 0;
        repeat (7) step();
        i_req = 0; d_req = 0;
        #1;
        chk("perf0_istall", z_perf_istall, 32'd7);
        chk("perf0_dstall", z_perf_dstall, 32'd0);
        chk("perf_istall", perf_istall, 32'd6);
        chk("perf_dstall", perf_dstall, 32'd1);
        step();
        reset = 0;
        #1;
        chk("perf_rst_istall", z_perf_istall, 32'd0);
        chk("perf_rst_dstall", perf_dstall, 32'd0);
        reset = 1;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
